// File: rtl/etch_cursor_ctrl_if.sv
// Framebuffer write port: a single-beat valid/ready pixel write.
// The controller drives the master side, the framebuffer the slave side.
interface etch_cursor_ctrl_if #(
  parameter int AW = 15
);
  logic          wr_en;     // write valid
  logic [AW-1:0] wr_addr;   // pixel address
  logic          wr_data;   // 1 = ink, 0 = clear
  logic          wr_ready;  // framebuffer accepts the write this cycle

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/etch_cursor_ctrl.sv
// Etch-A-Sketch cursor controller.
// Turns two debounced quadrature encoders into a saturating cursor position,
// issues one ink write per real cursor move, and runs a full-screen clear
// sweep on a clear-button press, followed by a redraw of the cursor dot.
module etch_cursor_ctrl #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int AW    = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                h_a,
  input  logic                h_b,
  input  logic                v_a,
  input  logic                v_b,
  input  logic                clear_btn,
  etch_cursor_ctrl_if.master  wr,
  output logic [XW-1:0]       cursor_x,
  output logic [YW-1:0]       cursor_y,
  output logic                clearing
);

  typedef enum logic [1:0] {
    IDLE,   // no write outstanding
    INK,    // a write (ink or post-sweep redraw) is waiting for wr_ready
    CLEAR   // sweeping zeros across every pixel address
  } state_t;

  localparam logic [XW-1:0] X_MAX     = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(V_RES - 1);
  localparam logic [XW-1:0] X_HOME    = XW'(H_RES / 2);
  localparam logic [YW-1:0] Y_HOME    = YW'(V_RES / 2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);

  state_t        state_q, state_d;
  logic          prev_h_a, prev_v_a, prev_clr, primed;
  logic          clr_pend_q, clr_pend_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic          wr_en_d, wr_data_d, clearing_d;
  logic [AW-1:0] wr_addr_d;

  logic          h_step, v_step, clr_rise;
  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic          moved;

  // Row-major pixel address; the multiply is by a constant so it folds to
  // shifts and adds. Legal parameters guarantee the result fits in AW bits.
  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x,
                                             input logic [YW-1:0] y);
    return AW'(y) * AW'(H_RES) + AW'(x);
  endfunction

  // Rising-edge detection; nothing counts until one edge has passed since
  // reset so inputs that are already high at release cause no step.
  assign h_step   = primed & h_a & ~prev_h_a;
  assign v_step   = primed & v_a & ~prev_v_a;
  assign clr_rise = primed & clear_btn & ~prev_clr;

  // Input history and primed flag, updated every cycle regardless of state
  // so an edge that arrives while the controller is busy is never replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_h_a <= 1'b0;
      prev_v_a <= 1'b0;
      prev_clr <= 1'b0;
      primed   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      prev_h_a <= h_a;
      prev_v_a <= v_a;
      prev_clr <= clear_btn;
      primed   <= 1'b1;
    end
  end

  // Candidate cursor position after this cycle's encoder steps, clamped to
  // the screen; a step into an edge leaves the position unchanged (null move).
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    step_x = cursor_x;
    step_y = cursor_y;
    if (h_step) begin
      if (h_b) begin
        if (cursor_x != '0) step_x = cursor_x - XW'(1);
      end else begin
        if (cursor_x != X_MAX) step_x = cursor_x + XW'(1);
      end
    end
    if (v_step) begin
      if (v_b) begin
        if (cursor_y != '0) step_y = cursor_y - YW'(1);
      end else begin
        if (cursor_y != Y_MAX) step_y = cursor_y + YW'(1);
      end
    end
    moved = (step_x != cursor_x) || (step_y != cursor_y);
  end

  // Next-state and next-output logic. "free" marks a cycle in which the
  // controller can start new work: idle, or the outstanding ink write is
  // being accepted right now (back-to-back writes without a bubble).
  always_comb begin
    logic free;
    free       = 1'b0;
    state_d    = state_q;
    x_d        = cursor_x;
    y_d        = cursor_y;
    wr_en_d    = wr.wr_en;
    wr_addr_d  = wr.wr_addr;
    wr_data_d  = wr.wr_data;
    clearing_d = clearing;
    clr_pend_d = clr_pend_q;

    case (state_q)
      IDLE: free = 1'b1;
      INK: begin
        if (wr.wr_ready) begin
          free = 1'b1;
        end else if (clr_rise) begin
          // Write stalled: remember the press, run the sweep once free.
          clr_pend_d = 1'b1;
        end
      end
      CLEAR: begin
        // Cursor steps and clear edges are ignored for the whole sweep.
        if (wr.wr_ready) begin
          if (wr.wr_addr == LAST_ADDR) begin
            clearing_d = 1'b0;
            state_d    = INK;
            wr_addr_d  = pix_addr(cursor_x, cursor_y);
            wr_data_d  = 1'b1;
          end else begin
            wr_addr_d = wr.wr_addr + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (free) begin
      if (clr_rise || clr_pend_q) begin
        // Clear wins over a simultaneous cursor step; that step is dropped.
        state_d    = CLEAR;
        clr_pend_d = 1'b0;
        clearing_d = 1'b1;
        wr_en_d    = 1'b1;
        wr_data_d  = 1'b0;
        wr_addr_d  = '0;
      end else if (moved) begin
        state_d   = INK;
        x_d       = step_x;
        y_d       = step_y;
        wr_en_d   = 1'b1;
        wr_data_d = 1'b1;
        wr_addr_d = pix_addr(step_x, step_y);
      end else begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    end
  end

  // FSM state register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_pend_q <= 1'b0;
      cursor_x   <= X_HOME;
      cursor_y   <= Y_HOME;
      wr.wr_en   <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= 1'b0;
      clearing   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      cursor_x   <= x_d;
      cursor_y   <= y_d;
      wr.wr_en   <= wr_en_d;
      wr.wr_addr <= wr_addr_d;
      wr.wr_data <= wr_data_d;
      clearing   <= clearing_d;
    end
  end

endmodule

// File: tb/tb_etch_cursor_ctrl.sv
// Self-checking bench for etch_cursor_ctrl: a hand-computed vector table,
// directed multi-cycle sequences (saturation, stall, clear sweep, reset
// mid-sweep) and a randomized phase compared against a pixel-level model.
module tb_etch_cursor_ctrl;
  localparam int H_RES = 160;
  localparam int V_RES = 120;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int AW    = 15;
  localparam int NPIX  = H_RES * V_RES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_a = 1'b0, h_b = 1'b0, v_a = 1'b0, v_b = 1'b0;
  logic          clear_btn = 1'b0;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic          clearing;

  etch_cursor_ctrl_if #(.AW(AW)) wr_bus ();

  etch_cursor_ctrl #(
    .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW), .AW(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .h_a(h_a),
    .h_b(h_b),
    .v_a(v_a),
    .v_b(v_b),
    .clear_btn(clear_btn),
    .wr(wr_bus),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .clearing(clearing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pixel-level view: the cursor as plain integers, plus the write currently
  // offered to the framebuffer and, while sweeping, the sweep index.
  int mx, my, m_addr;
  bit m_en, m_data, m_sweep, m_pend, m_primed, p_ha, p_va, p_clr;

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    mx = H_RES / 2; my = V_RES / 2; m_addr = 0;
    m_en = 0; m_data = 0; m_sweep = 0; m_pend = 0;
    m_primed = 0; p_ha = 0; p_va = 0; p_clr = 0;
  endtask

  task automatic model_step(input bit ha, hb, va, vb, clr, rdy);
    bit hr, vr, cr;
    int nx, ny;
    hr = m_primed && ha && !p_ha;
    vr = m_primed && va && !p_va;
    cr = m_primed && clr && !p_clr;
    if (m_sweep) begin
      if (rdy) begin
        if (m_addr == NPIX - 1) begin
          m_sweep = 0; m_data = 1; m_addr = my * H_RES + mx;
        end else begin
          m_addr = m_addr + 1;
        end
      end
    end else if (m_en && !rdy) begin
      if (cr) m_pend = 1;
    end else if (cr || m_pend) begin
      m_pend = 0; m_sweep = 1; m_en = 1; m_data = 0; m_addr = 0;
    end else begin
      nx = clamp(mx + (hr ? (hb ? -1 : 1) : 0), H_RES - 1);
      ny = clamp(my + (vr ? (vb ? -1 : 1) : 0), V_RES - 1);
      if (nx != mx || ny != my) begin
        mx = nx; my = ny; m_en = 1; m_data = 1; m_addr = ny * H_RES + nx;
      end else begin
        m_en = 0;
      end
    end
    p_ha = ha; p_va = va; p_clr = clr; m_primed = 1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".x"}, 32'(cursor_x), mx);
    check({tag, ".y"}, 32'(cursor_y), my);
    check({tag, ".wr_en"}, 32'(wr_bus.wr_en), 32'(m_en));
    check({tag, ".clearing"}, 32'(clearing), 32'(m_sweep));
    if (m_en) begin
      check({tag, ".wr_addr"}, 32'(wr_bus.wr_addr), m_addr);
      check({tag, ".wr_data"}, 32'(wr_bus.wr_data), 32'(m_data));
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit ha, hb, va, vb, clr, rdy);
    h_a = ha; h_b = hb; v_a = va; v_b = vb; clear_btn = clr;
    wr_bus.wr_ready = rdy;
    model_step(ha, hb, va, vb, clr, rdy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit ha, hb, va, vb, rdy;
    bit en;
    int x, y, addr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, late, bad, clr_cycles, dropped;
    bit tog, found;

    // Inputs held high through reset release must not cause a step.
    vecs[0]  = '{1, 0, 1, 0, 1, 0, 80, 60, 0};
    vecs[1]  = '{1, 0, 1, 0, 1, 0, 80, 60, 0};
    vecs[2]  = '{0, 0, 1, 0, 1, 0, 80, 60, 0};
    vecs[3]  = '{1, 0, 1, 0, 1, 1, 81, 60, 9681};
    vecs[4]  = '{1, 0, 1, 0, 1, 0, 81, 60, 0};
    vecs[5]  = '{1, 0, 0, 0, 1, 0, 81, 60, 0};
    vecs[6]  = '{1, 0, 1, 1, 1, 1, 81, 59, 9521};
    vecs[7]  = '{0, 0, 0, 0, 1, 0, 81, 59, 0};
    vecs[8]  = '{1, 1, 1, 0, 1, 1, 80, 60, 9680};   // simultaneous steps
    vecs[9]  = '{0, 0, 0, 0, 1, 0, 80, 60, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 1, 81, 60, 9681};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 81, 60, 9681};   // stalled, held
    vecs[12] = '{1, 0, 0, 0, 0, 1, 81, 60, 9681};   // step during stall dropped
    vecs[13] = '{0, 0, 0, 0, 1, 0, 81, 60, 0};
    vecs[14] = '{1, 0, 0, 0, 1, 1, 82, 60, 9682};
    vecs[15] = '{1, 0, 0, 0, 1, 0, 82, 60, 0};

    // ---- reset state ----
    h_a = 1; v_a = 1; wr_bus.wr_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.x", 32'(cursor_x), 80);
    check("rst.y", 32'(cursor_y), 60);
    check("rst.wr_en", 32'(wr_bus.wr_en), 0);
    check("rst.wr_addr", 32'(wr_bus.wr_addr), 0);
    check("rst.wr_data", 32'(wr_bus.wr_data), 0);
    check("rst.clearing", 32'(clearing), 0);
    rst_n = 1;

    // ---- vector table ----
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].ha, vecs[i].hb, vecs[i].va, vecs[i].vb, 1'b0, vecs[i].rdy);
      check($sformatf("vec%0d.x", i), 32'(cursor_x), vecs[i].x);
      check($sformatf("vec%0d.y", i), 32'(cursor_y), vecs[i].y);
      check($sformatf("vec%0d.wr_en", i), 32'(wr_bus.wr_en), 32'(vecs[i].en));
      if (vecs[i].en) begin
        check($sformatf("vec%0d.wr_addr", i), 32'(wr_bus.wr_addr), vecs[i].addr);
        check($sformatf("vec%0d.wr_data", i), 32'(wr_bus.wr_data), 1);
      end
    end

    // ---- left saturation: 87 steps from x=82 -> 82 writes, last 5 null ----
    pulses = 0; late = 0;
    for (int i = 0; i < 87; i++) begin
      cyc(0, 1, 0, 0, 0, 1);
      if (wr_bus.wr_en) begin pulses++; if (i >= 82) late++; end
      cyc(1, 1, 0, 0, 0, 1);
      if (wr_bus.wr_en) begin pulses++; if (i >= 82) late++; end
      cmp_model("satx");
    end
    check("satx.writes", pulses, 82);
    check("satx.null_writes", late, 0);
    check("satx.x", 32'(cursor_x), 0);

    // ---- top saturation: 62 up-steps from y=60 -> 59 writes, y=119 ----
    pulses = 0;
    for (int i = 0; i < 62; i++) begin
      cyc(1, 1, 0, 0, 0, 1);
      if (wr_bus.wr_en) pulses++;
      cyc(1, 1, 1, 0, 0, 1);
      if (wr_bus.wr_en) pulses++;
    end
    check("saty.writes", pulses, 59);
    check("saty.y", 32'(cursor_y), 119);
    cmp_model("saty");

    // ---- 5-cycle stall with a dropped step ----
    cyc(0, 0, 1, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 0);
    check("stall.move.x", 32'(cursor_x), 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc((i != 0), 0, 1, 0, 0, 0);
      if (wr_bus.wr_en !== 1'b1 || wr_bus.wr_addr !== AW'(19041) ||
          wr_bus.wr_data !== 1'b1 || cursor_x !== XW'(1)) bad++;
    end
    check("stall.held_cycles_bad", bad, 0);
    cyc(1, 0, 1, 0, 0, 1);
    check("stall.release.wr_en", 32'(wr_bus.wr_en), 0);
    check("stall.release.x", 32'(cursor_x), 1);
    cmp_model("stall");

    // ---- clear sweep with encoder activity; clear held high afterwards ----
    cyc(1, 0, 1, 0, 1, 1);
    check("sweep.start.clearing", 32'(clearing), 1);
    check("sweep.start.wr_addr", 32'(wr_bus.wr_addr), 0);
    check("sweep.start.wr_data", 32'(wr_bus.wr_data), 0);
    clr_cycles = 1; bad = 0; tog = 1;
    for (int i = 0; i < NPIX + 100; i++) begin
      tog = ~tog;
      cyc(tog, 0, tog, 0, 1, 1);
      if (!clearing) break;
      if (wr_bus.wr_addr !== AW'(clr_cycles) || wr_bus.wr_data !== 1'b0 ||
          wr_bus.wr_en !== 1'b1) bad++;
      clr_cycles++;
    end
    check("sweep.clearing_cycles", clr_cycles, NPIX);
    check("sweep.addr_seq_bad", bad, 0);
    check("sweep.redraw.wr_en", 32'(wr_bus.wr_en), 1);
    check("sweep.redraw.wr_addr", 32'(wr_bus.wr_addr), 19041);
    check("sweep.redraw.wr_data", 32'(wr_bus.wr_data), 1);
    check("sweep.cursor_x", 32'(cursor_x), 1);
    check("sweep.cursor_y", 32'(cursor_y), 119);
    cyc(tog, 0, tog, 0, 1, 1);
    check("sweep.after.wr_en", 32'(wr_bus.wr_en), 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(tog, 0, tog, 0, 1, 1);
      if (clearing !== 1'b0) bad++;
    end
    check("sweep.single_sweep_bad", bad, 0);
    cmp_model("sweep");

    // ---- reset at sweep address 5000, then restart ----
    cyc(tog, 0, tog, 0, 0, 1);
    cyc(tog, 0, tog, 0, 1, 1);
    found = 0;
    for (int i = 0; i < 6000; i++) begin
      if (wr_bus.wr_addr == AW'(5000)) begin found = 1; break; end
      cyc(tog, 0, tog, 0, 1, 1);
    end
    check("rstmid.reached_5000", 32'(found), 1);
    #2 rst_n = 0;
    #1;
    check("rstmid.clearing", 32'(clearing), 0);
    check("rstmid.wr_en", 32'(wr_bus.wr_en), 0);
    check("rstmid.x", 32'(cursor_x), 80);
    check("rstmid.y", 32'(cursor_y), 60);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    cyc(tog, 0, tog, 0, 1, 1);
    check("rstmid.no_resume", 32'(clearing), 0);
    cyc(tog, 0, tog, 0, 0, 1);
    cyc(tog, 0, tog, 0, 1, 1);
    check("restart.clearing", 32'(clearing), 1);
    check("restart.wr_addr", 32'(wr_bus.wr_addr), 0);
    cyc(tog, 0, tog, 0, 1, 0);
    cyc(tog, 0, tog, 0, 1, 1);
    cmp_model("restart");

    // ---- pending clear: press during an ink stall ----
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    check("pend.stall.clearing", 32'(clearing), 0);
    cyc(1, 0, 0, 0, 1, 1);
    check("pend.taken.clearing", 32'(clearing), 1);
    cmp_model("pend");

    // ---- randomized encoder / ready activity ----
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    dropped = 0;
    for (int blk = 0; blk < 6; blk++) begin
      int bias_h, bias_v;
      bias_h = $urandom_range(0, 100);
      bias_v = $urandom_range(0, 100);
      for (int i = 0; i < 500; i++) begin
        cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < bias_h),
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < bias_v),
            1'b0, ($urandom_range(0, 99) < 65));
        cmp_model("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
